rr_arb_mux_nto1: RTL and testbench



---
 rtl/rr_arb_mux_nto1.sv | 225 ++++++++++++++++++++++
 tb/tb_rr_arb_mux_nto1.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_nto1.sv
// rr_arb_mux_nto1
// ----------------------------------------------------------------------------
// Round-robin arbiter plus N-to-1 valid/ready/payload mux. It shares one
// destination port between N source ports. A grant is held across multi-beat
// packets, which end with a last flag. A grant is also held while the
// destination stalls a beat, so a presented beat never changes under
// backpressure.
//
// Parameters:
//   N      number of source ports (2..16)
//   PLD_W  payload width in bits
//   IDX_W  width of the grant index (derived from N; leave at default)
//
// Ports:
//   clk       clock; all state changes on the rising edge
//   rst_n     asynchronous active-low reset
//   vld_src   per-source valid, bit i belongs to source i
//   pld_src   packed payloads, source i at [i*PLD_W +: PLD_W]
//   last_src  per-source last-beat-of-packet flag
//   rdy_src   per-source ready (only the granted bit can be high)
//   vld_dst   destination valid
//   pld_dst   destination payload (zero when nothing is granted)
//   last_dst  destination last flag (zero when nothing is granted)
//   rdy_dst   destination ready
//   gnt_oh    one-hot current grant, zero when nothing is granted
//   gnt_idx   binary index of the current grant, zero when gnt_oh is zero
//   locked    high while a grant is being held
//
// Build option:
//   RR_MUX_OUT_REG_EN  When this macro is defined, a two-entry skid buffer
//                      registers the destination side. This adds one cycle of
//                      latency. Source ready then comes from the buffer's
//                      not-full flag.
// ----------------------------------------------------------------------------
module rr_arb_mux_nto1 #(
    parameter int N     = 3,
    parameter int PLD_W = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       vld_src,
    input  logic [N*PLD_W-1:0] pld_src,
    input  logic [N-1:0]       last_src,
    output logic [N-1:0]       rdy_src,
    output logic               vld_dst,
    output logic [PLD_W-1:0]   pld_dst,
    output logic               last_dst,
    input  logic               rdy_dst,
    output logic [N-1:0]       gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               locked
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   lock_idx;

    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_sel;
    logic [IDX_W:0]     cand;

    logic               sel_vld;
    logic               sel_last;
    logic [PLD_W-1:0]   sel_pld;
    logic               sel_rdy;
    logic               src_hs;

    // Advance the priority pointer. An explicit compare is used so that
    // non-power-of-two N wraps back to 0.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(N - 1)) begin
            return '0;
        end
        return v + IDX_W'(1);
    endfunction

    // Grant selection.
    // While locked, the held index wins unconditionally.
    // Otherwise, scan from ptr upward with wrap-around and take the first
    // valid source.
    // Reset masks the grant so that nothing is presented while rst_n is low.
    always_comb begin
        gnt_any = 1'b0;
        gnt_sel = '0;
        cand    = '0;
        if (!rst_n) begin
            gnt_any = 1'b0;
        end else if (state == LOCK) begin
            gnt_any = 1'b1;
            gnt_sel = lock_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (cand >= (IDX_W + 1)'(N)) begin
                    cand = cand - (IDX_W + 1)'(N);
                end
                if (!gnt_any && vld_src[cand[IDX_W-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_sel = cand[IDX_W-1:0];
                end
            end
        end
    end

    // Source-side mux.
    // This picks the granted source's valid, last and payload, and builds
    // the one-hot grant. Every value stays zero when there is no grant.
    always_comb begin
        gnt_oh   = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_pld  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_any && (gnt_sel == IDX_W'(i))) begin
                gnt_oh[i] = 1'b1;
                sel_vld   = vld_src[i];
                sel_last  = last_src[i];
                sel_pld   = pld_src[i*PLD_W +: PLD_W];
            end
        end
    end

    assign gnt_idx = gnt_sel;
    assign rdy_src = gnt_oh & {N{sel_rdy}};
    assign src_hs  = sel_vld && sel_rdy;

`ifdef RR_MUX_OUT_REG_EN

    logic [PLD_W:0] buf_mem [2];
    logic           buf_wr;
    logic           buf_rd;
    logic [1:0]     buf_cnt;
    logic           buf_push;
    logic           buf_pop;

    assign sel_rdy  = (buf_cnt != 2'd2);
    assign buf_push = src_hs;
    assign vld_dst  = (buf_cnt != 2'd0);
    assign buf_pop  = vld_dst && rdy_dst;

    assign {last_dst, pld_dst} = vld_dst ? buf_mem[buf_rd] : '0;

    // Two-entry skid buffer.
    // Writing and reading in the same cycle keeps the occupancy constant.
    // This lets a continuously ready destination take one beat per cycle,
    // and the second entry absorbs the beat that is in flight when the
    // destination stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            buf_wr     <= 1'b0;
            buf_rd     <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (buf_push) begin
                buf_mem[buf_wr] <= {sel_last, sel_pld};
                buf_wr          <= ~buf_wr;
            end
            if (buf_pop) begin
                buf_rd <= ~buf_rd;
            end
            case ({buf_push, buf_pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

`else

    // Zero-latency path: the destination sees the granted source directly.
    assign sel_rdy  = rdy_dst;
    assign vld_dst  = sel_vld;
    assign pld_dst  = sel_pld;
    assign last_dst = sel_last;

`endif

    // Grant FSM.
    // In IDLE, any presented beat that does not complete a packet locks the
    // grant. This covers both a stalled beat and an accepted non-last beat.
    // A single-beat packet that completes in IDLE only rotates the pointer.
    // In LOCK, the grant is released only by the last handshake. The
    // pointer then moves to the source just after the one that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
            locked   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld && !(src_hs && sel_last)) begin
                        state    <= LOCK;
                        lock_idx <= gnt_sel;
                        locked   <= 1'b1;
                    end else if (src_hs && sel_last) begin
                        ptr <= wrap_inc(gnt_sel);
                    end
                end
                LOCK: begin
                    if (src_hs && sel_last) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                        ptr    <= wrap_inc(lock_idx);
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb_mux_nto1.sv
// tb_rr_arb_mux_nto1
// ----------------------------------------------------------------------------
// Directed bench for rr_arb_mux_nto1 in its default build (N=3, PLD_W=4).
// It covers:
//   - reset state
//   - round-robin fairness
//   - packet lock
//   - backpressure hold
//   - a source dropping valid while locked
//   - reset in the middle of a packet
// ----------------------------------------------------------------------------
module tb_rr_arb_mux_nto1;

    localparam int N     = 3;
    localparam int PLD_W = 4;
    localparam int IDX_W = $clog2(N);

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       vld_src;
    logic [N*PLD_W-1:0] pld_src;
    logic [N-1:0]       last_src;
    logic [N-1:0]       rdy_src;
    logic               vld_dst;
    logic [PLD_W-1:0]   pld_dst;
    logic               last_dst;
    logic               rdy_dst;
    logic [N-1:0]       gnt_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               locked;

    int n_cmp;
    int n_fail;

    rr_arb_mux_nto1 #(
        .N     (N),
        .PLD_W (PLD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_src  (vld_src),
        .pld_src  (pld_src),
        .last_src (last_src),
        .rdy_src  (rdy_src),
        .vld_dst  (vld_dst),
        .pld_dst  (pld_dst),
        .last_dst (last_dst),
        .rdy_dst  (rdy_dst),
        .gnt_oh   (gnt_oh),
        .gnt_idx  (gnt_idx),
        .locked   (locked)
    );

    // Free-running clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and keep the
    // counts used by the summary line.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle so
    // that the combinational outputs can be sampled before the next rise.
    task automatic apply_stimulus(input logic [2:0] v, input logic [2:0] l,
                                  input logic [3:0] p0, input logic [3:0] p1,
                                  input logic [3:0] p2, input logic r);
        @(negedge clk);
        vld_src  = v;
        last_src = l;
        pld_src  = {p2, p1, p0};
        rdy_dst  = r;
        #1;
    endtask

    // Directed sequence. Each expected value is worked out by hand from the
    // round-robin rules, with the pointer position tracked in the comments.
    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        vld_src  = 3'b111;
        last_src = 3'b111;
        pld_src  = {4'hC, 4'hB, 4'hA};
        rdy_dst  = 1'b1;

        // Reset held with every source valid: nothing is presented.
        @(negedge clk);
        #1;
        check_output("rst_vld_dst", vld_dst, 0);
        check_output("rst_gnt_oh", gnt_oh, 0);
        check_output("rst_locked", locked, 0);
        check_output("rst_rdy_src", rdy_src, 0);

        // Release reset. With ptr=0, source 0 wins first.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rel_gnt_oh", gnt_oh, 3'b001);
        check_output("fair_pld_0", pld_dst, 4'hA);

        // Fairness: single-beat packets from all sources give 0,1,2,0,1,2.
        for (int k = 1; k < 6; k++) begin
            apply_stimulus(3'b111, 3'b111, 4'hA, 4'hB, 4'hC, 1'b1);
            check_output($sformatf("fair_idx_%0d", k), gnt_idx, k % 3);
            check_output($sformatf("fair_oh_%0d", k), gnt_oh, 3'b001 << (k % 3));
            check_output($sformatf("fair_pld_%0d", k), pld_dst, 4'hA + (k % 3));
            check_output($sformatf("fair_rdy_%0d", k), rdy_src, 3'b001 << (k % 3));
            check_output($sformatf("fair_lock_%0d", k), locked, 0);
        end

        // ptr=0. A single beat from source 0 alone moves ptr to 1.
        apply_stimulus(3'b001, 3'b111, 4'h5, 4'hB, 4'hC, 1'b1);
        check_output("solo0_idx", gnt_idx, 0);
        check_output("solo0_pld", pld_dst, 4'h5);

        // Packet lock: source 1 sends three beats while 0 and 2 are valid.
        apply_stimulus(3'b111, 3'b101, 4'hA, 4'h1, 4'hC, 1'b1);
        check_output("pkt_b1_idx", gnt_idx, 1);
        check_output("pkt_b1_pld", pld_dst, 4'h1);
        check_output("pkt_b1_last", last_dst, 0);
        check_output("pkt_b1_lock", locked, 0);
        apply_stimulus(3'b111, 3'b101, 4'hA, 4'h2, 4'hC, 1'b1);
        check_output("pkt_b2_idx", gnt_idx, 1);
        check_output("pkt_b2_pld", pld_dst, 4'h2);
        check_output("pkt_b2_lock", locked, 1);
        apply_stimulus(3'b111, 3'b111, 4'hA, 4'h3, 4'hC, 1'b1);
        check_output("pkt_b3_idx", gnt_idx, 1);
        check_output("pkt_b3_last", last_dst, 1);
        check_output("pkt_b3_lock", locked, 1);
        apply_stimulus(3'b111, 3'b111, 4'hA, 4'hB, 4'hC, 1'b1);
        check_output("pkt_next2_idx", gnt_idx, 2);
        check_output("pkt_next2_lock", locked, 0);
        apply_stimulus(3'b111, 3'b111, 4'hA, 4'hB, 4'hC, 1'b1);
        check_output("pkt_next0_idx", gnt_idx, 0);

        // ptr=1. Backpressure: source 2 alone with the destination stalled.
        apply_stimulus(3'b100, 3'b100, 4'hA, 4'hB, 4'h5, 1'b0);
        check_output("bp_c0_idx", gnt_idx, 2);
        check_output("bp_c0_vld", vld_dst, 1);
        check_output("bp_c0_rdy", rdy_src, 0);
        for (int k = 1; k < 4; k++) begin
            apply_stimulus(3'b100, 3'b100, 4'hA, 4'hB, 4'h5, 1'b0);
            check_output($sformatf("bp_c%0d_idx", k), gnt_idx, 2);
            check_output($sformatf("bp_c%0d_pld", k), pld_dst, 4'h5);
            check_output($sformatf("bp_c%0d_lock", k), locked, 1);
        end
        apply_stimulus(3'b101, 3'b101, 4'h6, 4'hB, 4'h5, 1'b0);
        check_output("bp_src0_idx", gnt_idx, 2);
        check_output("bp_src0_pld", pld_dst, 4'h5);
        check_output("bp_src0_rdy", rdy_src, 0);
        apply_stimulus(3'b101, 3'b101, 4'h6, 4'hB, 4'h5, 1'b1);
        check_output("bp_rel_idx", gnt_idx, 2);
        check_output("bp_rel_rdy", rdy_src, 3'b100);
        apply_stimulus(3'b101, 3'b101, 4'h6, 4'hB, 4'h5, 1'b1);
        check_output("bp_after_idx", gnt_idx, 0);
        check_output("bp_after_pld", pld_dst, 4'h6);

        // ptr=1. No requests: everything on the destination side is zero.
        apply_stimulus(3'b000, 3'b111, 4'h6, 4'hB, 4'h5, 1'b1);
        check_output("none_oh", gnt_oh, 0);
        check_output("none_idx", gnt_idx, 0);
        check_output("none_vld", vld_dst, 0);
        check_output("none_pld", pld_dst, 0);
        check_output("none_last", last_dst, 0);

        // Source 1 starts a packet, drops valid while locked, then resumes.
        apply_stimulus(3'b010, 3'b000, 4'h0, 4'h7, 4'h0, 1'b1);
        check_output("mid_b1_idx", gnt_idx, 1);
        apply_stimulus(3'b000, 3'b000, 4'h0, 4'h7, 4'h0, 1'b1);
        check_output("drop_vld", vld_dst, 0);
        check_output("drop_oh", gnt_oh, 3'b010);
        check_output("drop_lock", locked, 1);
        apply_stimulus(3'b010, 3'b000, 4'h0, 4'h8, 4'h0, 1'b1);
        check_output("mid_b2_pld", pld_dst, 4'h8);
        check_output("mid_b2_lock", locked, 1);

        // Pulse reset during the second beat. The FSM returns to IDLE, ptr=0.
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_lock", locked, 0);
        check_output("mid_rst_oh", gnt_oh, 0);
        check_output("mid_rst_vld", vld_dst, 0);
        rst_n    = 1'b1;
        vld_src  = 3'b110;
        last_src = 3'b110;
        #1;
        check_output("post_rst_12_idx", gnt_idx, 1);
        check_output("post_rst_12_lock", locked, 0);
        vld_src = 3'b101;
        #1;
        check_output("post_rst_02_idx", gnt_idx, 0);
        vld_src = 3'b000;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
